// File: rtl/trap_pkg.sv
// Shared types for the trap controller: FSM states, cause codes, and the
// priority encoder that selects one cause from the execute-stage exception flags.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  localparam logic [3:0] CAUSE_BKPT      = 4'd3;
  localparam logic [3:0] CAUSE_LD_MISAL  = 4'd4;
  localparam logic [3:0] CAUSE_LD_ACCESS = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISAL  = 4'd6;
  localparam logic [3:0] CAUSE_ST_ACCESS = 4'd7;
  localparam logic [3:0] CAUSE_LD_PAGE   = 4'd13;
  localparam logic [3:0] CAUSE_ST_PAGE   = 4'd15;

  localparam int BIT_LD_MISAL  = 0;
  localparam int BIT_LD_ACCESS = 1;
  localparam int BIT_ST_MISAL  = 2;
  localparam int BIT_ST_ACCESS = 3;
  localparam int BIT_LD_PAGE   = 4;
  localparam int BIT_ST_PAGE   = 5;
  localparam int BIT_BKPT      = 6;

  typedef struct packed {
    logic       valid;
    logic [3:0] cause;
    logic       use_pc;
  } prio_t;

  // Breakpoint first, then misaligned, then page faults, then access faults.
  function automatic prio_t prio_enc(input logic [6:0] ex);
    prio_t r;
    r = '0;
    r.valid = |ex;
    if (ex[BIT_BKPT]) begin
      r.cause  = CAUSE_BKPT;
      r.use_pc = 1'b1;
    end else if (ex[BIT_ST_MISAL]) begin
      r.cause = CAUSE_ST_MISAL;
    end else if (ex[BIT_LD_MISAL]) begin
      r.cause = CAUSE_LD_MISAL;
    end else if (ex[BIT_ST_PAGE]) begin
      r.cause = CAUSE_ST_PAGE;
    end else if (ex[BIT_LD_PAGE]) begin
      r.cause = CAUSE_LD_PAGE;
    end else if (ex[BIT_ST_ACCESS]) begin
      r.cause = CAUSE_ST_ACCESS;
    end else if (ex[BIT_LD_ACCESS]) begin
      r.cause = CAUSE_LD_ACCESS;
    end
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Fetch redirect handshake between the trap controller (master) and the
// fetch PC mux (slave).
interface trap_ctrl_if #(parameter int N = 64) ();
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         redirect_ready;

  modport master (output redirect_valid, output redirect_pc, input redirect_ready);
  modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/trap_csr.sv
// Trap CSR bank: mepc/mcause/mtval written together on trap commit, mtvec
// written by the CSR path at any time (direct mode, low bits forced to zero).
module trap_csr #(
  parameter int           N         = 64,
  parameter logic [N-1:0] RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         trap_we,
  input  logic [N-1:0] trap_pc,
  input  logic [3:0]   trap_cause,
  input  logic [N-1:0] trap_tval,
  input  logic         mtvec_we,
  input  logic [N-1:0] mtvec_wdata,
  output logic [N-1:0] mepc,
  output logic [N-1:0] mcause,
  output logic [N-1:0] mtval,
  output logic [N-1:0] mtvec
);

  localparam logic [N-1:0] LOW2_MASK = ~N'(3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mepc   <= '0;
      mcause <= '0;
      mtval  <= '0;
      mtvec  <= RESET_VEC;
    end else begin
      if (trap_we) begin
        mepc   <= trap_pc & LOW2_MASK;
        mcause <= {{(N-4){1'b0}}, trap_cause};
        mtval  <= trap_tval;
      end
      if (mtvec_we) begin
        mtvec <= mtvec_wdata & LOW2_MASK;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry / mret return sequencer: selects the exception cause, flushes the
// pipeline, commits the trap CSRs and redirects fetch through a handshake.
//
//   state       | meaning
//   ST_IDLE     | waiting for an exception or mret from execute
//   ST_FLUSH    | flush+stall held for FLUSH_CYCLES cycles
//   ST_COMMIT   | one stall cycle; trap CSRs written on the trap path
//   ST_REDIRECT | redirect offered to fetch until redirect_ready
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int           N            = 64,
  parameter int           FLUSH_CYCLES = 2,
  parameter logic [N-1:0] RESET_VEC    = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [6:0]      exceptSignal,
  input  logic [N-1:0]    except_pc,
  input  logic [N-1:0]    except_addr,
  input  logic            mret,
  input  logic            mtvec_we,
  input  logic [N-1:0]    mtvec_wdata,
  output logic            stall,
  output logic            flush,
  trap_ctrl_if.master     rdr,
  output logic [N-1:0]    mepc,
  output logic [N-1:0]    mcause,
  output logic [N-1:0]    mtval,
  output logic [N-1:0]    mtvec
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           is_ret;
  logic [3:0]     lat_cause;
  logic [N-1:0]   lat_pc;
  logic [N-1:0]   lat_tval;
  prio_t          sel;
  logic           csr_we;

  assign sel    = prio_enc(exceptSignal);
  assign csr_we = (state == ST_COMMIT) && !is_ret;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= ST_IDLE;
      cnt                <= '0;
      is_ret             <= 1'b0;
      lat_cause          <= '0;
      lat_pc             <= '0;
      lat_tval           <= '0;
      stall              <= 1'b0;
      flush              <= 1'b0;
      rdr.redirect_valid <= 1'b0;
      rdr.redirect_pc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel.valid || mret) begin
            // An exception in the same cycle as mret wins; the mret is dropped.
            is_ret <= !sel.valid;
            if (sel.valid) begin
              lat_cause <= sel.cause;
              lat_pc    <= except_pc;
              lat_tval  <= sel.use_pc ? except_pc : except_addr;
            end
            state <= ST_FLUSH;
            flush <= 1'b1;
            stall <= 1'b1;
            cnt   <= CW'(FLUSH_CYCLES - 1);
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            state <= ST_COMMIT;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_COMMIT: begin
          // Target captured here so a later mtvec write cannot disturb the offer.
          state              <= ST_REDIRECT;
          rdr.redirect_valid <= 1'b1;
          rdr.redirect_pc    <= is_ret ? mepc : mtvec;
        end
        ST_REDIRECT: begin
          if (rdr.redirect_ready) begin
            state              <= ST_IDLE;
            rdr.redirect_valid <= 1'b0;
            stall              <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  trap_csr #(
    .N         (N),
    .RESET_VEC (RESET_VEC)
  ) u_csr (
    .clk         (clk),
    .reset_n     (reset_n),
    .trap_we     (csr_we),
    .trap_pc     (lat_pc),
    .trap_cause  (lat_cause),
    .trap_tval   (lat_tval),
    .mtvec_we    (mtvec_we),
    .mtvec_wdata (mtvec_wdata),
    .mepc        (mepc),
    .mcause      (mcause),
    .mtval       (mtval),
    .mtvec       (mtvec)
  );

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, priority, stalled redirect,
// mret return and mid-sequence reset with hand-computed expectations.
module tb_trap_ctrl;
  localparam int N = 64;

  logic         clk;
  logic         reset_n;
  logic [6:0]   exceptSignal;
  logic [N-1:0] except_pc;
  logic [N-1:0] except_addr;
  logic         mret;
  logic         mtvec_we;
  logic [N-1:0] mtvec_wdata;
  logic         stall;
  logic         flush;
  logic [N-1:0] mepc;
  logic [N-1:0] mcause;
  logic [N-1:0] mtval;
  logic [N-1:0] mtvec;

  int n_checks = 0;
  int n_fail   = 0;

  trap_ctrl_if #(.N(N)) rif ();

  trap_ctrl #(.N(N), .FLUSH_CYCLES(2), .RESET_VEC('0)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .exceptSignal (exceptSignal),
    .except_pc    (except_pc),
    .except_addr  (except_addr),
    .mret         (mret),
    .mtvec_we     (mtvec_we),
    .mtvec_wdata  (mtvec_wdata),
    .stall        (stall),
    .flush        (flush),
    .rdr          (rif),
    .mepc         (mepc),
    .mcause       (mcause),
    .mtval        (mtval),
    .mtvec        (mtvec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the test");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic f, input logic v);
    chk({tag, "_stall"}, N'(stall), N'(s));
    chk({tag, "_flush"}, N'(flush), N'(f));
    chk({tag, "_valid"}, N'(rif.redirect_valid), N'(v));
  endtask

  initial begin
    reset_n            = 1'b0;
    exceptSignal       = '0;
    except_pc          = '0;
    except_addr        = '0;
    mret               = 1'b0;
    mtvec_we           = 1'b0;
    mtvec_wdata        = '0;
    rif.redirect_ready = 1'b0;
    step(); step();
    chk_ctl("rst_hold", 0, 0, 0);
    reset_n = 1'b1;
    step();

    chk_ctl("idle", 0, 0, 0);
    chk("idle_rpc", rif.redirect_pc, 64'h0);
    chk("idle_mepc", mepc, 64'h0);
    chk("idle_mcause", mcause, 64'h0);
    chk("idle_mtval", mtval, 64'h0);
    chk("idle_mtvec", mtvec, 64'h0);

    // mtvec write drops the mode bits
    mtvec_we = 1'b1; mtvec_wdata = 64'h8000_0003;
    step();
    mtvec_we = 1'b0;
    chk("mtvec_wr", mtvec, 64'h8000_0000);

    // load misaligned trap
    exceptSignal = 7'b0000001; except_addr = 64'h1003; except_pc = 64'h400;
    rif.redirect_ready = 1'b1;
    step();
    exceptSignal = '0;
    chk_ctl("lm_f1", 1, 1, 0);
    step();
    chk_ctl("lm_f2", 1, 1, 0);
    step();
    chk_ctl("lm_commit", 1, 0, 0);
    chk("lm_mcause_pre", mcause, 64'h0);
    step();
    chk_ctl("lm_redir", 1, 0, 1);
    chk("lm_rpc", rif.redirect_pc, 64'h8000_0000);
    chk("lm_mcause", mcause, 64'd4);
    chk("lm_mtval", mtval, 64'h1003);
    chk("lm_mepc", mepc, 64'h400);
    step();
    chk_ctl("lm_idle", 0, 0, 0);

    // breakpoint beats store/load misaligned; redirect held off for 5 cycles
    rif.redirect_ready = 1'b0;
    exceptSignal = 7'b1000101; except_pc = 64'h806; except_addr = 64'h2000;
    step();
    exceptSignal = '0;
    step(); step(); step();
    chk_ctl("bp_redir", 1, 0, 1);
    chk("bp_mcause", mcause, 64'd3);
    chk("bp_mtval", mtval, 64'h806);
    chk("bp_mepc", mepc, 64'h804);
    chk("bp_rpc0", rif.redirect_pc, 64'h8000_0000);
    for (int i = 0; i < 5; i++) begin
      exceptSignal = (i == 1) ? 7'b0000001 : 7'b0;
      mret         = (i == 1);
      mtvec_we     = (i == 3);
      mtvec_wdata  = 64'h9001;
      step();
      chk("bp_wait_valid", N'(rif.redirect_valid), 64'h1);
      chk("bp_wait_rpc", rif.redirect_pc, 64'h8000_0000);
      chk("bp_wait_flush", N'(flush), 64'h0);
    end
    mtvec_we = 1'b0;
    chk("bp_mtvec_new", mtvec, 64'h9000);
    rif.redirect_ready = 1'b1;
    step();
    chk_ctl("bp_idle", 0, 0, 0);
    step();
    chk_ctl("bp_ignored", 0, 0, 0);
    chk("bp_mcause_kept", mcause, 64'd3);

    // exception and mret together: exception wins
    exceptSignal = 7'b0000100; mret = 1'b1; except_pc = 64'h500; except_addr = 64'h3004;
    step();
    exceptSignal = '0; mret = 1'b0;
    step(); step(); step();
    chk_ctl("sm_redir", 1, 0, 1);
    chk("sm_mcause", mcause, 64'd6);
    chk("sm_mtval", mtval, 64'h3004);
    chk("sm_mepc", mepc, 64'h500);
    chk("sm_rpc", rif.redirect_pc, 64'h9000);
    step();
    chk_ctl("sm_idle", 0, 0, 0);

    // standalone mret returns to mepc, CSRs untouched
    mret = 1'b1; except_pc = 64'hdead; except_addr = 64'hbeef;
    step();
    mret = 1'b0;
    chk_ctl("mr_f1", 1, 1, 0);
    step(); step(); step();
    chk_ctl("mr_redir", 1, 0, 1);
    chk("mr_rpc", rif.redirect_pc, 64'h500);
    chk("mr_mcause", mcause, 64'd6);
    chk("mr_mtval", mtval, 64'h3004);
    chk("mr_mepc", mepc, 64'h500);
    step();
    chk_ctl("mr_idle", 0, 0, 0);

    // reset in the middle of FLUSH
    exceptSignal = 7'b0000010; except_pc = 64'h600; except_addr = 64'h4000;
    step();
    exceptSignal = '0;
    chk_ctl("rf_flush", 1, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    chk_ctl("rf_cleared", 0, 0, 0);
    chk("rf_mtvec", mtvec, 64'h0);
    chk("rf_mcause", mcause, 64'h0);
    chk("rf_mepc", mepc, 64'h0);
    step();
    reset_n = 1'b1;
    step();
    chk_ctl("rf_idle", 0, 0, 0);

    // store page fault outranks load page, store access and load access
    exceptSignal = 7'b0111010; except_pc = 64'h70b; except_addr = 64'h5000;
    step();
    exceptSignal = '0;
    chk_ctl("pf_f1", 1, 1, 0);
    step(); step(); step();
    chk_ctl("pf_redir", 1, 0, 1);
    chk("pf_mcause", mcause, 64'd15);
    chk("pf_mtval", mtval, 64'h5000);
    chk("pf_mepc", mepc, 64'h708);
    chk("pf_rpc", rif.redirect_pc, 64'h0);
    step();
    chk_ctl("pf_idle", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Sequences synchronous trap entry and `mret` return for the 64-bit core. It accepts the 7-bit memory-exception vector produced by the execute-stage exception detector and picks the highest-priority cause. It then flushes the pipeline, commits `mepc`/`mcause`/`mtval`, and redirects fetch to `mtvec` through a valid/ready handshake. It sits between execute-stage exception detection and the fetch PC mux, and owns the trap CSRs.

## Interface
- `N`, 64, datapath/CSR width
- `FLUSH_CYCLES`, 2, cycles `flush` is held asserted (≥1)
- `RESET_VEC`, 0, reset value of `mtvec`
- `clk`  in  1  clock, all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `exceptSignal`  in  7  per-cause flags from execute stage
- `except_pc`  in  N  PC of the excepting instruction
- `except_addr`  in  N  faulting data address
- `mret`  in  1  execute-stage `mret` retiring
- `mtvec_we`  in  1  CSR write strobe for `mtvec`
- `mtvec_wdata`  in  N  `mtvec` write data
- `stall`  out  1  freeze fetch/decode while controller busy
- `flush`  out  1  kill all in-flight instructions
- `redirect_valid`  out  1  new PC offered to fetch
- `redirect_pc`  out  N  target PC
- `redirect_ready`  in  1  fetch accepts redirect
- `mepc`, `mcause`, `mtval`, `mtvec`  out  N each  trap CSR contents

## Operation
- `exceptSignal` bit map: [0] load misaligned (cause 4), [1] load access fault (5), [2] store misaligned (6), [3] store access fault (7), [4] load page fault (13), [5] store page fault (15), [6] breakpoint (3).
- Priority, high to low: bit6, bit2, bit0, bit5, bit4, bit3, bit1.
- `mcause` = zero-extended cause code. Bit N-1 is always 0, since this block raises no interrupts.
- `mtval`:
  - breakpoint: `except_pc`.
  - all other causes: `except_addr`.
- `mtvec` write: stores `mtvec_wdata` with bits [1:0] forced to 0 (direct mode only).
  - Accepted in any state.
  - If a write coincides with a REDIRECT cycle, the redirect uses the pre-write value. The new value applies from the next cycle.
- FSM states: IDLE, FLUSH, COMMIT, REDIRECT.
  - IDLE, `|exceptSignal`: latch cause, `except_pc`, and the selected tval. Go to FLUSH.
  - IDLE, `mret` with no exception: set `ret` flag. Go to FLUSH.
  - IDLE, exception and `mret` in the same cycle: the exception wins and `mret` is dropped.
  - FLUSH: `flush`=1 and `stall`=1 for `FLUSH_CYCLES` cycles, counted by an internal down-counter. Then go to COMMIT.
  - COMMIT: one cycle with `stall`=1.
    - Trap path: write `mepc`←latched PC (bits [1:0] cleared), `mcause`, `mtval`.
    - `mret` path: no CSR write.
    - Go to REDIRECT.
  - REDIRECT: `redirect_valid`=1 and `stall`=1.
    - `redirect_pc` = `mtvec` on the trap path, `mepc` on the `mret` path.
    - Hold `redirect_valid` and `redirect_pc` stable until `redirect_ready`. On the handshake cycle go to IDLE.
- `exceptSignal` and `mret` are ignored outside IDLE, because those instructions are being flushed.
- Reset, including mid-sequence:
  - `mtvec`=`RESET_VEC`; `mepc`, `mcause`, `mtval` = 0.
  - FSM→IDLE; all handshake and control outputs 0.

## Timing
- Exception seen at edge t (IDLE): `flush` high in cycles t+1 … t+`FLUSH_CYCLES`.
- COMMIT is cycle t+`FLUSH_CYCLES`+1. CSRs are visible at t+`FLUSH_CYCLES`+2.
- `redirect_valid` first high at t+`FLUSH_CYCLES`+2. Minimum entry-to-handshake latency is `FLUSH_CYCLES`+2 cycles.
- Back-to-back: a new exception is accepted in the cycle after the handshake, at the earliest.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Structure
- Shared package `trap_pkg`:
  - state enum
  - cause-code constants
  - `exceptSignal` bit-index localparams
  - priority encoder function returning {valid, cause, use_pc_as_tval}
- One natural sub-module: `trap_csr`, holding the `mepc`/`mcause`/`mtval`/`mtvec` registers and write ports. The FSM stays in `trap_ctrl`.

## Test plan
- Reset, then idle: all outputs 0 and `mtvec`=`RESET_VEC`. Write `mtvec`=0x8000_0003 → reads back 0x8000_0000.
- `exceptSignal`=7'b0000001, `except_addr`=0x1003, `except_pc`=0x400, `redirect_ready`=1:
  - `flush` high for 2 cycles.
  - then `mcause`=4, `mtval`=0x1003, `mepc`=0x400.
  - `redirect_pc`=`mtvec`.
  - returns to IDLE.
- `exceptSignal`=7'b1000101 (breakpoint + store misaligned + load misaligned): `mcause`=3 and `mtval`=`except_pc`.
- `redirect_ready` held low for 5 cycles: `redirect_valid`/`redirect_pc` stable throughout; `exceptSignal` pulses during the wait are ignored.
- `mret` and `exceptSignal`=7'b0000100 in the same cycle: trap taken with `mcause`=6. A later standalone `mret` redirects to `mepc` with CSRs unchanged.
- `reset_n` asserted low during FLUSH: outputs clear immediately. After release, the FSM is in IDLE and accepts a new exception normally.
